// File: rtl/aes_pkg.sv
// Shared AES constants: forward S-box, key-schedule round constants, lookup helper.
package aes_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned SBOX_DEPTH = 256;
    localparam int unsigned RCON_DEPTH = 16;

    // FIPS-197 forward S-box, row-major by high nibble.
    localparam logic [BYTE_W-1:0] SBOX [SBOX_DEPTH] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Round constants; index 0 and 11..15 are unused by AES-128 and read as zero.
    localparam logic [BYTE_W-1:0] RCON [RCON_DEPTH] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic logic [BYTE_W-1:0] sbox(input logic [BYTE_W-1:0] b);
        return SBOX[b];
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Single-byte forward S-box ROM (combinational).
//   data  : byte to substitute
//   subst : SBOX[data]
module aes_sbox
    import aes_pkg::*;
(
    input  logic [BYTE_W-1:0] data,
    output logic [BYTE_W-1:0] subst
);

    always_comb begin
        subst = sbox(data);
    end

endmodule

// File: rtl/rcon_sub_bytes.sv
// Registered AES SubBytes over N_BYTES bytes plus the key-schedule Rcon column.
//   clk, reset  : rising-edge clock, synchronous active-high reset
//   enable      : capture strobe; outputs update one clock later
//   state_in    : bytes to substitute, byte i at [8i+7:8i]
//   round_num   : round index 0..15 for the Rcon lookup
//   state_out   : registered bytewise S-box of state_in
//   rcon_column : registered {RCON[round_num], 24'h0}
//   valid       : high the cycle after an enabled capture
module rcon_sub_bytes
    import aes_pkg::*;
#(
    parameter int unsigned N_BYTES = 4
)
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [BYTE_W*N_BYTES-1:0]  state_in,
    input  logic [3:0]                 round_num,
    output logic [BYTE_W*N_BYTES-1:0]  state_out,
    output logic [31:0]                rcon_column,
    output logic                       valid
);

    localparam int unsigned STATE_W = BYTE_W * N_BYTES;

    logic [STATE_W-1:0] sub_c;

    // One independent S-box per byte lane.
    for (genvar i = 0; i < int'(N_BYTES); i++) begin : g_lane
        aes_sbox u_sbox (
            .data  (state_in[BYTE_W*i +: BYTE_W]),
            .subst (sub_c[BYTE_W*i +: BYTE_W])
        );
    end

    // Output register: reset wins over enable; idle holds data and drops valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_out   <= '0;
            rcon_column <= '0;
            valid       <= 1'b0;
        end else if (enable) begin
            state_out   <= sub_c;
            rcon_column <= {RCON[round_num], 24'h000000};
            valid       <= 1'b1;
        end else begin
            valid       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rcon_sub_bytes.sv
module tb_rcon_sub_bytes;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic [3:0]   round_num;
    logic [31:0]  s4_in;
    logic [127:0] s16_in;
    logic [31:0]  s4_out;
    logic [127:0] s16_out;
    logic [31:0]  rc4, rc16;
    logic         v4, v16;

    int n_vec = 0;
    int n_err = 0;

    // Model state
    logic [31:0]  m_s4;
    logic [127:0] m_s16;
    logic [31:0]  m_rc;
    logic         m_v;
    logic [7:0]   ref_sbox [256];

    always #5 clk = ~clk;

    rcon_sub_bytes #(.N_BYTES(4)) dut4 (
        .clk(clk), .reset(reset), .enable(enable), .state_in(s4_in),
        .round_num(round_num), .state_out(s4_out), .rcon_column(rc4), .valid(v4)
    );

    rcon_sub_bytes #(.N_BYTES(16)) dut16 (
        .clk(clk), .reset(reset), .enable(enable), .state_in(s16_in),
        .round_num(round_num), .state_out(s16_out), .rcon_column(rc16), .valid(v16)
    );

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] t = {x, x} << n;
        return t[15:8];
    endfunction

    // S-box from its definition: multiplicative inverse then affine map.
    function automatic logic [7:0] sbox_math(input logic [7:0] a);
        logic [7:0] inv = 8'h00;
        if (a != 8'h00) begin
            inv = 8'h01;
            for (int k = 0; k < 254; k++) inv = gmul(inv, a);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    // Rcon: powers of x in GF(2^8) for rounds 1..10, zero otherwise.
    function automatic logic [7:0] rc_math(input int r);
        logic [7:0] v = 8'h01;
        if (r < 1 || r > 10) return 8'h00;
        for (int k = 1; k < r; k++) v = gmul(v, 8'h02);
        return v;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the model, compare both DUTs.
    task automatic step(input logic rst, input logic en, input logic [31:0] a4,
                        input logic [127:0] a16, input logic [3:0] r);
        reset = rst; enable = en; s4_in = a4; s16_in = a16; round_num = r;
        @(posedge clk);
        #1;
        if (rst) begin
            m_s4 = '0; m_s16 = '0; m_rc = '0; m_v = 1'b0;
        end else if (en) begin
            for (int i = 0; i < 4; i++)  m_s4[8*i +: 8]  = ref_sbox[a4[8*i +: 8]];
            for (int i = 0; i < 16; i++) m_s16[8*i +: 8] = ref_sbox[a16[8*i +: 8]];
            m_rc = {rc_math(int'(r)), 24'h000000};
            m_v  = 1'b1;
        end else begin
            m_v = 1'b0;
        end
        check("state4",  128'(s4_out), 128'(m_s4));
        check("state16", s16_out,      m_s16);
        check("rcon4",   128'(rc4),    128'(m_rc));
        check("rcon16",  128'(rc16),   128'(m_rc));
        check("valid4",  128'(v4),     128'(m_v));
        check("valid16", 128'(v16),    128'(m_v));
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [31:0]  w4;
        logic [127:0] w16;
        for (int i = 0; i < 256; i++) ref_sbox[i] = sbox_math(8'(i));
        m_s4 = '0; m_s16 = '0; m_rc = '0; m_v = 1'b0;

        // Reset with enable high and all-ones data
        step(1'b1, 1'b1, 32'hffffffff, {128{1'b1}}, 4'd1);
        step(1'b1, 1'b1, 32'hffffffff, {128{1'b1}}, 4'd1);
        check("reset_state_const", 128'(s4_out), 128'h0);

        // Key-schedule word
        step(1'b0, 1'b1, 32'hcf4f3c09, {4{32'hcf4f3c09}}, 4'd1);
        check("key_word_const", 128'(s4_out), 128'h8a84eb01);
        check("key_rcon_const", 128'(rc4), 128'h01000000);
        check("key_xor_const", 128'(s4_out ^ rc4), 128'h8b84eb01);

        // Spot S-box vector
        step(1'b0, 1'b1, 32'h00015300, 128'h0, 4'd0);
        check("spot_const", 128'(s4_out), 128'h637ced63);

        // Rcon sweep with single-cycle enables
        for (int r = 0; r < 16; r++) begin
            step(1'b0, 1'b1, $urandom, rand128(), 4'(r));
            step(1'b0, 1'b0, $urandom, rand128(), 4'($urandom));
        end

        // S-box sweep: every lane visits every byte value
        for (int v = 0; v < 256; v++) begin
            for (int i = 0; i < 4; i++)  w4[8*i +: 8]  = 8'(v + 67 * i);
            for (int i = 0; i < 16; i++) w16[8*i +: 8] = 8'(v + 16 * i);
            step(1'b0, 1'b1, w4, w16, 4'($urandom));
        end

        // Hold: capture zeros then idle while inputs toggle
        step(1'b0, 1'b1, 32'h0, 128'h0, 4'd3);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b0, (k % 2) ? 32'hffffffff : 32'h5a5a5a5a, rand128(), 4'($urandom));
            check("hold_const", 128'(s4_out), 128'h63636363);
        end

        // Mid-stream reset pulse under continuous enable
        for (int k = 0; k < 10; k++) begin
            step(k == 5, 1'b1, $urandom, rand128(), 4'($urandom));
        end

        // Random mix of enable, idle and occasional reset
        for (int k = 0; k < 300; k++) begin
            step(($urandom % 23) == 0, ($urandom % 3) != 0, $urandom, rand128(), 4'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
